// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet TX path (frame buffer and TX FSM).
package eth_tx_pkg;

    localparam int pMAX_PAYLOAD_BYTES = 1500;
    localparam int pFRM_LEN_WIDTH     = 11;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DATA,
        WR_DROP
    } eth_tx_buf_wr_state_t;

endpackage

// File: rtl/eth_tx_len_fifo.sv
// Committed-frame length FIFO; head is presented combinationally.
module eth_tx_len_fifo #(
    parameter int pDEPTH = 4,
    parameter int pWIDTH = 11
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [pWIDTH-1:0] push_data_i,
    input  logic              pop_i,
    output logic [pWIDTH-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(pDEPTH);

    logic [pWIDTH-1:0] mem_q [pDEPTH];
    logic [AW:0]       wr_q;
    logic [AW:0]       rd_q;
    logic              do_push;
    logic              do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    // A pop frees the slot on the same edge, so push-while-full is fine when popping.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_frame_buffer.sv
// Byte-wide TX frame buffer: stores whole frames in a circular RAM and releases
// them to the RMII TX FSM only once committed.
//
// state   | meaning
// WR_IDLE | waiting for the first byte of a frame
// WR_DATA | frame in progress, bytes written tentatively past cm_ptr
// WR_DROP | frame rejected, discarding bytes up to and including Wr_Last
module eth_tx_frame_buffer #(
    parameter int pDEPTH             = 2048,
    parameter int pADDR_WIDTH        = $clog2(pDEPTH),
    parameter int pMAX_FRAMES        = 4,
    parameter int pMAX_PAYLOAD_BYTES = 1500
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [7:0]                          wr_data_i,
    input  logic                                wr_valid_i,
    input  logic                                wr_last_i,
    output logic                                wr_ready_o,
    output logic                                frm_avail_o,
    output logic [eth_tx_pkg::pFRM_LEN_WIDTH-1:0] frm_len_o,
    input  logic                                rd_en_i,
    output logic [7:0]                          rd_data_o,
    output logic                                rd_valid_o,
    output logic                                rd_last_o,
    output logic [15:0]                         drop_cnt_o
);

    import eth_tx_pkg::*;

    localparam int PW = pADDR_WIDTH + 1;
    localparam int LW = pFRM_LEN_WIDTH;
    localparam logic [PW-1:0] FULL_DIFF = PW'(pDEPTH);
    localparam logic [LW-1:0] MAX_LEN   = LW'(pMAX_PAYLOAD_BYTES);

    logic [7:0] ram_q [pDEPTH];

    eth_tx_buf_wr_state_t st_q, st_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] cm_ptr_q, cm_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] len_next;
    logic [LW-1:0] rcnt_q;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic          ready_en_q;
    logic [7:0]    rd_data_q;
    logic          rd_valid_q;
    logic          rd_last_q;

    logic          wr_fire;
    logic          ram_full;
    logic          ram_we;
    logic          fifo_push;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_head;
    logic          rd_fire;
    logic          rd_is_last;

    // Full test uses the pre-edge rd_ptr, so a same-cycle read never frees space early.
    assign ram_full   = ((wr_ptr_q - rd_ptr_q) == FULL_DIFF);
    assign wr_ready_o = ready_en_q && !((st_q == WR_IDLE) && fifo_full);
    assign wr_fire    = wr_valid_i && wr_ready_o;
    assign len_next   = (st_q == WR_IDLE) ? LW'(1) : len_q + LW'(1);

    always_comb begin
        st_d       = st_q;
        wr_ptr_d   = wr_ptr_q;
        cm_ptr_d   = cm_ptr_q;
        len_d      = len_q;
        drop_cnt_d = drop_cnt_q;
        ram_we     = 1'b0;
        fifo_push  = 1'b0;
        if (wr_fire) begin
            case (st_q)
                WR_IDLE, WR_DATA: begin
                    if (ram_full || (len_next > MAX_LEN)) begin
                        wr_ptr_d   = cm_ptr_q;
                        len_d      = '0;
                        drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
                        st_d       = wr_last_i ? WR_IDLE : WR_DROP;
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (wr_last_i) begin
                            fifo_push = 1'b1;
                            cm_ptr_d  = wr_ptr_q + 1'b1;
                            len_d     = '0;
                            st_d      = WR_IDLE;
                        end else begin
                            len_d = len_next;
                            st_d  = WR_DATA;
                        end
                    end
                end
                WR_DROP: begin
                    if (wr_last_i) begin
                        st_d = WR_IDLE;
                    end
                end
                default: st_d = WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q       <= WR_IDLE;
            wr_ptr_q   <= '0;
            cm_ptr_q   <= '0;
            len_q      <= '0;
            drop_cnt_q <= '0;
            ready_en_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            wr_ptr_q   <= wr_ptr_d;
            cm_ptr_q   <= cm_ptr_d;
            len_q      <= len_d;
            drop_cnt_q <= drop_cnt_d;
            ready_en_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            ram_q[wr_ptr_q[pADDR_WIDTH-1:0]] <= wr_data_i;
        end
    end

    assign rd_fire    = rd_en_i && !fifo_empty;
    assign rd_is_last = ((rcnt_q + LW'(1)) == fifo_head);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            rcnt_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            rd_last_q  <= rd_fire && rd_is_last;
            if (rd_fire) begin
                rd_data_q <= ram_q[rd_ptr_q[pADDR_WIDTH-1:0]];
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rcnt_q    <= rd_is_last ? '0 : rcnt_q + LW'(1);
            end
        end
    end

    eth_tx_len_fifo #(
        .pDEPTH (pMAX_FRAMES),
        .pWIDTH (LW)
    ) u_len_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (fifo_push),
        .push_data_i (len_next),
        .pop_i       (rd_fire && rd_is_last),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign frm_avail_o = !fifo_empty;
    assign frm_len_o   = fifo_empty ? '0 : fifo_head;
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_last_o   = rd_last_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_eth_tx_frame_buffer.sv
// Directed bench for eth_tx_frame_buffer: frame round-trips, FIFO full, drops, wrap, reset.
`timescale 1ns/1ps
module tb_eth_tx_frame_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  wr_data_i;
    logic        wr_valid_i;
    logic        wr_last_i;
    logic        wr_ready_o;
    logic        frm_avail_o;
    logic [10:0] frm_len_o;
    logic        rd_en_i;
    logic [7:0]  rd_data_o;
    logic        rd_valid_o;
    logic        rd_last_o;
    logic [15:0] drop_cnt_o;

    int n_chk = 0;
    int n_bad = 0;

    eth_tx_frame_buffer dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_data_i   (wr_data_i),
        .wr_valid_i  (wr_valid_i),
        .wr_last_i   (wr_last_i),
        .wr_ready_o  (wr_ready_o),
        .frm_avail_o (frm_avail_o),
        .frm_len_o   (frm_len_o),
        .rd_en_i     (rd_en_i),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o),
        .rd_last_o   (rd_last_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #10 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        wr_data_i  = d;
        wr_valid_i = 1'b1;
        wr_last_i  = last;
        @(negedge clk_i);
        while (!wr_ready_o && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        if (!wr_ready_o) begin
            chk("wr_ready_timeout", 32'(wr_ready_o), 1);
            wr_valid_i = 1'b0;
            wr_last_i  = 1'b0;
        end else begin
            @(posedge clk_i);
            #1;
            wr_valid_i = 1'b0;
            wr_last_i  = 1'b0;
        end
    endtask

    task automatic send_frame(input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            send_byte(8'(base + i), (i == len - 1));
        end
    endtask

    task automatic read_frame(input int len, input logic [7:0] base, input string tag);
        int bad;
        int lasts;
        int lastpos;
        bad     = 0;
        lasts   = 0;
        lastpos = -1;
        chk({tag, "_avail"}, 32'(frm_avail_o), 1);
        chk({tag, "_len"}, 32'(frm_len_o), len);
        for (int i = 0; i < len; i++) begin
            rd_en_i = 1'b1;
            @(posedge clk_i);
            #1;
            if (!rd_valid_o || rd_data_o !== 8'(base + i)) bad++;
            if (rd_last_o) begin
                lasts++;
                lastpos = i;
            end
        end
        rd_en_i = 1'b0;
        chk({tag, "_data_errs"}, bad, 0);
        chk({tag, "_last_pos"}, lastpos, len - 1);
        chk({tag, "_last_cnt"}, lasts, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_ready"}, 32'(wr_ready_o), 0);
        chk({tag, "_avail"}, 32'(frm_avail_o), 0);
        chk({tag, "_len"}, 32'(frm_len_o), 0);
        chk({tag, "_rd_data"}, 32'(rd_data_o), 0);
        chk({tag, "_rd_valid"}, 32'(rd_valid_o), 0);
        chk({tag, "_rd_last"}, 32'(rd_last_o), 0);
        chk({tag, "_drop_cnt"}, 32'(drop_cnt_o), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i      = 1'b1;
        wr_data_i  = 8'h00;
        wr_valid_i = 1'b0;
        wr_last_i  = 1'b0;
        rd_en_i    = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk_reset_outputs("rst");
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rdy_before_edge", 32'(wr_ready_o), 0);
        @(posedge clk_i);
        #1;
        chk("rdy_after_edge", 32'(wr_ready_o), 1);

        // 46-byte frame 0x00..0x2D; partial frame must stay invisible
        for (int i = 0; i < 45; i++) send_byte(8'(i), 1'b0);
        chk("t1_partial_hidden", 32'(frm_avail_o), 0);
        send_byte(8'h2D, 1'b1);
        read_frame(46, 8'h00, "t1");
        chk("t1_empty_after", 32'(frm_avail_o), 0);

        // fill the length FIFO with four frames
        send_frame(1, 8'h80);
        send_frame(60, 8'h10);
        send_frame(1500, 8'h33);
        send_frame(64, 8'hC0);
        chk("t2_ready_full", 32'(wr_ready_o), 0);
        wr_data_i  = 8'hAA;
        wr_valid_i = 1'b1;
        wr_last_i  = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("t2_ready_held", 32'(wr_ready_o), 0);
        wr_valid_i = 1'b0;
        wr_last_i  = 1'b0;
        read_frame(1, 8'h80, "t2f0");
        chk("t2_ready_after_pop", 32'(wr_ready_o), 1);
        read_frame(60, 8'h10, "t2f1");
        read_frame(1500, 8'h33, "t2f2");
        read_frame(64, 8'hC0, "t2f3");
        chk("t2_empty_after", 32'(frm_avail_o), 0);
        chk("t2_drop_cnt", 32'(drop_cnt_o), 0);

        // oversize frame is dropped by length
        send_frame(1501, 8'h00);
        chk("t3_drop_cnt", 32'(drop_cnt_o), 1);
        chk("t3_no_avail", 32'(frm_avail_o), 0);
        send_frame(10, 8'h5A);
        read_frame(10, 8'h5A, "t3");

        // RAM full at byte 549 of a 600-byte frame behind an unread 1500-byte frame
        send_frame(1500, 8'h21);
        send_frame(600, 8'h77);
        chk("t4_drop_cnt", 32'(drop_cnt_o), 2);
        read_frame(1500, 8'h21, "t4a");
        chk("t4_no_dropped_frame", 32'(frm_avail_o), 0);
        send_frame(600, 8'h77);
        read_frame(600, 8'h77, "t4b");
        chk("t4_drop_cnt_hold", 32'(drop_cnt_o), 2);

        // commit lands on the same edge as the final-byte read of the previous frame
        send_frame(8, 8'hA0);
        fork
            read_frame(8, 8'hA0, "t5a");
            begin
                repeat (3) @(posedge clk_i);
                #1;
                send_frame(5, 8'hB0);
            end
        join
        read_frame(5, 8'hB0, "t5b");
        chk("t5_empty_after", 32'(frm_avail_o), 0);

        // reset while a frame is being written and another is being read
        send_frame(20, 8'h60);
        for (int i = 0; i < 10; i++) send_byte(8'(8'hE0 + i), 1'b0);
        rd_en_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        chk_reset_outputs("t6_rst");
        rd_en_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("t6_no_avail", 32'(frm_avail_o), 0);
        send_frame(64, 8'h01);
        read_frame(64, 8'h01, "t6");
        chk("t6_empty_after", 32'(frm_avail_o), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
